ros2_sub_msg_fifo: RTL and testbench

//  Multi-bank message buffer for the ROS2 subscriber application-data write port.

---
 rtl/ros2_sub_msg_fifo_if.sv | 41 ++++
 rtl/ros2_sub_msg_fifo.sv | 136 +++++++++++++
 tb/tb_ros2_sub_msg_fifo.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ros2_sub_msg_fifo_if.sv
// Purpose : bundles the ROS2 subscriber message-buffer write port, read port
//           and status/counter signals into one interface.
// Ports   : master = message source + consumer (drives wr_*, rd_ready, rd_addr,
//           drop_clr); slave = the buffer (drives rd_valid, rd_len, rd_data,
//           msg_count, drop_count, last_byte0).
interface ros2_sub_msg_fifo_if #(
   parameter int AW     = 6,
   parameter int BW     = 2,
   parameter int DROP_W = 16
);
   // write side (from the ROS2 application-data port)
   logic [AW-1:0]     wr_addr;
   logic              wr_ce;
   logic              wr_we;
   logic [7:0]        wr_wdata;
   logic [7:0]        wr_len;
   logic              wr_recv;
   // read side (to user logic)
   logic              rd_valid;
   logic              rd_ready;
   logic [7:0]        rd_len;
   logic [AW-1:0]     rd_addr;
   logic [7:0]        rd_data;
   // status
   logic [BW:0]       msg_count;
   logic [DROP_W-1:0] drop_count;
   logic              drop_clr;
   logic [7:0]        last_byte0;

   modport master (
      output wr_addr, wr_ce, wr_we, wr_wdata, wr_len, wr_recv,
      output rd_ready, rd_addr, drop_clr,
      input  rd_valid, rd_len, rd_data, msg_count, drop_count, last_byte0
   );

   modport slave (
      input  wr_addr, wr_ce, wr_we, wr_wdata, wr_len, wr_recv,
      input  rd_ready, rd_addr, drop_clr,
      output rd_valid, rd_len, rd_data, msg_count, drop_count, last_byte0
   );
endinterface

// File: rtl/ros2_sub_msg_fifo.sv
// Purpose : multi-bank message buffer. Incoming bytes are captured into the bank at
//           the write pointer and committed on wr_recv; committed messages are read
//           in FIFO order through a random-access port and released with a pop.
// Latency : commit visible one cycle after wr_recv; rd_data is registered (1 cycle).
// Backpressure: none on the write side -- a message arriving while every bank is
//           full is dropped and counted; rd_ready only pops while rd_valid.
// Ports   : clk, rst_n (async, active low) plus the slave side of
//           ros2_sub_msg_fifo_if (wr_* write port, rd_* read port, status counters).
module ros2_sub_msg_fifo #(
   parameter int MAX_LEN   = 64,
   parameter int NUM_BANKS = 4,
   parameter int DROP_W    = 16,
   parameter int AW        = $clog2(MAX_LEN),
   parameter int BW        = $clog2(NUM_BANKS)
) (
   input  logic               clk,
   input  logic               rst_n,
   ros2_sub_msg_fifo_if.slave bus
);
   localparam int LAW = $clog2(MAX_LEN);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_CAPTURE = 2'd1;
   localparam logic [1:0] ST_DROP    = 2'd2;

   logic [7:0]        mem [NUM_BANKS][MAX_LEN];
   logic [7:0]        len_tab [NUM_BANKS];
   logic [1:0]        state;
   logic [BW-1:0]     wp;
   logic [BW-1:0]     rp;
   logic [BW:0]       count;
   logic [7:0]        shadow0;
   logic [DROP_W-1:0] drop_cnt;
   logic [7:0]        last_b0;
   logic [7:0]        rd_data_q;

   logic              wr_hit;
   logic              full;
   logic              capture_wr;
   logic              do_commit;
   logic              do_drop;
   logic              do_pop;
   logic [7:0]        len_clamped;
   logic [7:0]        byte0_now;
   logic [LAW-1:0]    wr_idx;
   logic [LAW-1:0]    rd_idx;

   // Addresses past the bank size are silently ignored; the compare is done one
   // bit wider so it also works when AW is wider than the bank index.
   assign wr_hit = bus.wr_ce & bus.wr_we &
                   ({1'b0, bus.wr_addr} < (AW+1)'(MAX_LEN));
   assign wr_idx = bus.wr_addr[LAW-1:0];
   assign rd_idx = bus.rd_addr[LAW-1:0];

   assign full = (count == (BW+1)'(NUM_BANKS));

   // A byte lands in the write bank when it opens a message on a non-full buffer
   // or continues a message already being captured. A capturing message can never
   // collide with a committed bank: wp only moves on commit.
   assign capture_wr = wr_hit & (((state == ST_IDLE) & ~full) | (state == ST_CAPTURE));

   // full is the pre-pop value, so a same-cycle pop never rescues an arrival.
   assign do_commit = bus.wr_recv & (state != ST_DROP) & ~full;
   assign do_drop   = bus.wr_recv & ~do_commit;
   assign do_pop    = bus.rd_ready & (count != '0);

   assign len_clamped = (bus.wr_len > 8'(MAX_LEN)) ? 8'(MAX_LEN) : bus.wr_len;

   // A byte 0 written in the commit cycle itself must win over the shadow copy.
   assign byte0_now = (capture_wr && (bus.wr_addr == '0)) ? bus.wr_wdata : shadow0;

   // Message storage is deliberately not reset.
   always_ff @(posedge clk) begin
      if (capture_wr) begin
         mem[wp][wr_idx] <= bus.wr_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         wp        <= '0;
         rp        <= '0;
         count     <= '0;
         shadow0   <= '0;
         drop_cnt  <= '0;
         last_b0   <= '0;
         rd_data_q <= '0;
         for (int i = 0; i < NUM_BANKS; i++) begin
            len_tab[i] <= '0;
         end
      end else begin
         // read port runs every cycle, head valid or not
         rd_data_q <= mem[rp][rd_idx];

         if (bus.wr_recv) begin
            state <= ST_IDLE;
         end else if (wr_hit && (state == ST_IDLE)) begin
            state <= full ? ST_DROP : ST_CAPTURE;
         end

         if (capture_wr && (bus.wr_addr == '0)) begin
            shadow0 <= bus.wr_wdata;
         end

         if (do_commit) begin
            len_tab[wp] <= len_clamped;
            last_b0     <= byte0_now;
            wp          <= wp + 1'b1;
         end

         if (do_pop) begin
            rp <= rp + 1'b1;
         end

         if (do_commit && !do_pop) begin
            count <= count + 1'b1;
         end else if (!do_commit && do_pop) begin
            count <= count - 1'b1;
         end

         if (bus.drop_clr) begin
            drop_cnt <= '0;
         end else if (do_drop && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + 1'b1;
         end
      end
   end

   assign bus.rd_valid   = (count != '0);
   assign bus.rd_len     = len_tab[rp];
   assign bus.rd_data    = rd_data_q;
   assign bus.msg_count  = count;
   assign bus.drop_count = drop_cnt;
   assign bus.last_byte0 = last_b0;
endmodule

// File: tb/tb_ros2_sub_msg_fifo.sv
// Purpose : self-checking bench for ros2_sub_msg_fifo. The driver keeps a message-level
//           model (queue of committed messages, drop counter, last byte 0) and pushes each
//           expected message into a scoreboard queue; an independent monitor compares the
//           DUT read port and status outputs after every clock edge.
module tb_ros2_sub_msg_fifo;
   localparam int MAX_LEN = 64;
   localparam int NB      = 4;
   localparam int DW      = 4;
   localparam int AW      = 7;   // one bit wider than needed so out-of-range writes can be issued
   localparam int BW      = 2;

   typedef struct packed {
      logic [7:0]           len;
      logic [MAX_LEN-1:0]   mask;
      logic [MAX_LEN*8-1:0] data;
   } msg_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   ros2_sub_msg_fifo_if #(.AW(AW), .BW(BW), .DROP_W(DW)) bus ();

   ros2_sub_msg_fifo #(
      .MAX_LEN(MAX_LEN), .NUM_BANKS(NB), .DROP_W(DW), .AW(AW), .BW(BW)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   int checks = 0;
   int errors = 0;

   // reference model state
   msg_t          exp_q[$];
   msg_t          cur;
   int            m_cnt;
   bit            m_active;
   bit            m_drop;
   logic [7:0]    m_sh;
   logic [7:0]    exp_lb0;
   logic [DW-1:0] exp_drop;
   int            mon_cnt;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic idle_in();
      bus.wr_ce    = 1'b0;
      bus.wr_we    = 1'b0;
      bus.wr_addr  = '0;
      bus.wr_wdata = '0;
      bus.wr_len   = '0;
      bus.wr_recv  = 1'b0;
      bus.rd_ready = 1'b0;
      bus.rd_addr  = '0;
      bus.drop_clr = 1'b0;
   endtask

   task automatic idle_wr();
      bus.wr_ce   = 1'b0;
      bus.wr_we   = 1'b0;
      bus.wr_recv = 1'b0;
   endtask

   // Apply the current inputs to the model for the coming edge, then advance to the
   // next falling edge.
   task automatic tick();
      bit wr, pop, full, commit, drop;
      int a;
      a      = int'(bus.wr_addr);
      wr     = bus.wr_ce && bus.wr_we && (a < MAX_LEN);
      pop    = bus.rd_ready && (m_cnt > 0);
      full   = (m_cnt == NB);
      commit = 1'b0;
      drop   = 1'b0;
      if (wr) begin
         if (!m_active) begin
            m_active = 1'b1;
            m_drop   = full;
         end
         if (!m_drop) begin
            cur.data[a*8 +: 8] = bus.wr_wdata;
            cur.mask[a]        = 1'b1;
            if (a == 0) m_sh = bus.wr_wdata;
         end
      end
      if (bus.wr_recv) begin
         if (!m_drop && !full) commit = 1'b1;
         else                  drop   = 1'b1;
         if (commit) begin
            cur.len = (int'(bus.wr_len) > MAX_LEN) ? 8'(MAX_LEN) : bus.wr_len;
            exp_q.push_back(cur);
            exp_lb0 = m_sh;
         end
         m_active = 1'b0;
         m_drop   = 1'b0;
         cur      = '0;
      end
      if (bus.drop_clr)                 exp_drop = '0;
      else if (drop && exp_drop != '1)  exp_drop = exp_drop + 1'b1;
      m_cnt = m_cnt + int'(commit) - int'(pop);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle_in();
      exp_q.delete();
      m_cnt = 0; m_active = 1'b0; m_drop = 1'b0; cur = '0;
      m_sh = '0; exp_lb0 = '0; exp_drop = '0;
      #1;
      chk("rst_rd_valid",   bus.rd_valid,   0);
      chk("rst_rd_len",     bus.rd_len,     0);
      chk("rst_rd_data",    bus.rd_data,    0);
      chk("rst_msg_count",  bus.msg_count,  0);
      chk("rst_drop_count", bus.drop_count, 0);
      chk("rst_last_byte0", bus.last_byte0, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // n bytes at addresses 0..n-1 (b0, b0+1, ...), recv on the last byte; n==0 is recv only
   task automatic send_msg(input int n, input logic [7:0] b0, input logic [7:0] len);
      bus.rd_ready = 1'b0;
      if (n == 0) begin
         bus.wr_recv = 1'b1;
         bus.wr_len  = len;
         tick();
      end
      for (int i = 0; i < n; i++) begin
         bus.wr_ce    = 1'b1;
         bus.wr_we    = 1'b1;
         bus.wr_addr  = AW'(i);
         bus.wr_wdata = b0 + 8'(i);
         bus.wr_recv  = (i == n - 1);
         bus.wr_len   = len;
         tick();
      end
      idle_wr();
   endtask

   task automatic drain();
      idle_wr();
      bus.rd_ready = 1'b1;
      repeat (NB + 1) tick();
      bus.rd_ready = 1'b0;
      chk("drain_empty", bus.rd_valid, 0);
   endtask

   task automatic rand_rd();
      bus.rd_ready = ($urandom_range(0, 5) == 0);
      bus.rd_addr  = AW'($urandom_range(0, 9));
      bus.drop_clr = ($urandom_range(0, 63) == 0);
   endtask

   // Monitor: just after each rising edge, compare DUT outputs against the scoreboard.
   initial begin
      msg_t h;
      mon_cnt = 0;
      forever begin
         @(posedge clk);
         #1;
         if (!rst_n) begin
            mon_cnt = 0;
         end else begin
            if (mon_cnt > 0 && exp_q.size() > 0) begin
               h = exp_q[0];
               if (int'(bus.rd_addr) < MAX_LEN && h.mask[int'(bus.rd_addr)])
                  chk("mon_rd_data", bus.rd_data, h.data[int'(bus.rd_addr)*8 +: 8]);
               if (bus.rd_ready) void'(exp_q.pop_front());
            end
            mon_cnt = exp_q.size();
            chk("mon_msg_count", bus.msg_count, mon_cnt);
            chk("mon_rd_valid",  bus.rd_valid,  (mon_cnt != 0));
            if (mon_cnt > 0) begin
               h = exp_q[0];
               chk("mon_rd_len", bus.rd_len, h.len);
            end
            chk("mon_drop_count", bus.drop_count, exp_drop);
            chk("mon_last_byte0", bus.last_byte0, exp_lb0);
         end
      end
   end

   initial begin
      idle_in();
      #1;
      do_reset();

      // T1: "hi!" then recv as its own cycle
      bus.wr_ce = 1'b1; bus.wr_we = 1'b1;
      bus.wr_addr = 7'd0; bus.wr_wdata = 8'h68; tick();
      bus.wr_addr = 7'd1; bus.wr_wdata = 8'h69; tick();
      bus.wr_addr = 7'd2; bus.wr_wdata = 8'h21; tick();
      idle_wr(); bus.wr_recv = 1'b1; bus.wr_len = 8'd3; tick();
      idle_wr();
      chk("t1_rd_valid",   bus.rd_valid,   1);
      chk("t1_rd_len",     bus.rd_len,     3);
      chk("t1_msg_count",  bus.msg_count,  1);
      chk("t1_last_byte0", bus.last_byte0, 8'h68);
      bus.rd_addr = 7'd1; tick();
      chk("t1_rd_data",    bus.rd_data,    8'h69);
      drain();

      // T2: fill four banks, fifth message dropped, pop in order
      do_reset();
      for (int k = 1; k <= 4; k++) send_msg(3, 8'(k), 8'd3);
      send_msg(3, 8'd5, 8'd3);
      chk("t2_drop_count", bus.drop_count, 1);
      chk("t2_msg_count",  bus.msg_count,  4);
      for (int k = 1; k <= 4; k++) begin
         bus.rd_addr = 7'd0; tick();
         chk("t2_head_byte0", bus.rd_data, k);
         bus.rd_ready = 1'b1; tick();
         bus.rd_ready = 1'b0;
      end
      chk("t2_rd_valid", bus.rd_valid, 0);

      // T3: pop does not rescue an arrival on a full buffer; commit+pop keeps count
      for (int k = 0; k < 4; k++) send_msg(2, 8'h10 + 8'(k), 8'd2);
      chk("t3_full", bus.msg_count, 4);
      bus.wr_ce = 1'b1; bus.wr_we = 1'b1; bus.wr_addr = 7'd0; bus.wr_wdata = 8'h77;
      bus.wr_recv = 1'b1; bus.wr_len = 8'd1; bus.rd_ready = 1'b1; tick();
      idle_wr(); bus.rd_ready = 1'b0;
      chk("t3_drop_msg_count",  bus.msg_count,  3);
      chk("t3_drop_drop_count", bus.drop_count, 2);
      bus.wr_ce = 1'b1; bus.wr_we = 1'b1; bus.wr_addr = 7'd0; bus.wr_wdata = 8'h88;
      bus.wr_recv = 1'b1; bus.wr_len = 8'd1; bus.rd_ready = 1'b1; tick();
      idle_wr(); bus.rd_ready = 1'b0;
      chk("t3_both_msg_count", bus.msg_count,  3);
      chk("t3_both_last_b0",   bus.last_byte0, 8'h88);
      drain();

      // T4: length clamp and out-of-range address ignored
      bus.wr_ce = 1'b1; bus.wr_we = 1'b1;
      bus.wr_addr = 7'd5;  bus.wr_wdata = 8'hA5; tick();
      bus.wr_addr = 7'd69; bus.wr_wdata = 8'h5A; tick();
      idle_wr(); bus.wr_recv = 1'b1; bus.wr_len = 8'd200; tick();
      idle_wr();
      chk("t4_rd_len", bus.rd_len, 64);
      bus.rd_addr = 7'd5; tick();
      chk("t4_rd_data", bus.rd_data, 8'hA5);
      drain();

      // T5: drop counter saturates, clear has priority over a same-cycle drop
      for (int k = 0; k < 4; k++) send_msg(1, 8'h40 + 8'(k), 8'd1);
      repeat (20) send_msg(0, 8'd0, 8'd4);
      chk("t5_saturated", bus.drop_count, 15);
      bus.drop_clr = 1'b1; tick();
      bus.drop_clr = 1'b0;
      chk("t5_cleared", bus.drop_count, 0);
      send_msg(0, 8'd0, 8'd4);
      chk("t5_after_clr", bus.drop_count, 1);
      bus.drop_clr = 1'b1; bus.wr_recv = 1'b1; tick();
      bus.drop_clr = 1'b0; idle_wr();
      chk("t5_clr_priority", bus.drop_count, 0);
      drain();

      // T6: reset in the middle of a capture, then a clean message
      bus.wr_ce = 1'b1; bus.wr_we = 1'b1;
      bus.wr_addr = 7'd0; bus.wr_wdata = 8'hEE; tick();
      bus.wr_addr = 7'd1; bus.wr_wdata = 8'hEF; tick();
      do_reset();
      send_msg(3, 8'hC0, 8'd3);
      chk("t6_msg_count",  bus.msg_count,  1);
      chk("t6_last_byte0", bus.last_byte0, 8'hC0);
      bus.rd_addr = 7'd2; tick();
      chk("t6_rd_data",    bus.rd_data,    8'hC2);
      drain();

      // randomized traffic, checked by the monitor against the model
      for (int m = 0; m < 300; m++) begin
         int  n;
         bit  did_recv;
         n        = $urandom_range(1, 10);
         did_recv = 1'b0;
         for (int i = 0; i < n && !did_recv; i++) begin
            rand_rd();
            bus.wr_ce    = ($urandom_range(0, 7) != 0);
            bus.wr_we    = ($urandom_range(0, 7) != 0);
            bus.wr_addr  = ($urandom_range(0, 15) == 0) ? AW'(64 + $urandom_range(0, 63)) : AW'(i);
            bus.wr_wdata = 8'($urandom);
            bus.wr_len   = 8'($urandom_range(0, 80));
            bus.wr_recv  = (i == n - 1) && ($urandom_range(0, 1) == 1);
            did_recv     = bus.wr_recv;
            tick();
         end
         if (!did_recv) begin
            rand_rd();
            idle_wr();
            bus.wr_recv = 1'b1;
            bus.wr_len  = 8'($urandom_range(0, 80));
            tick();
         end
         repeat ($urandom_range(0, 3)) begin
            rand_rd();
            idle_wr();
            tick();
         end
      end
      bus.drop_clr = 1'b0;
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
